trap_handler: RTL and testbench
===============================

// Module: trap_handler
// PURPOSE
//  Consumer side of the trap path. Accepts exception requests from the trap
//  detector and the machine external interrupt, and saves machine-mode trap
//  state (mepc/mcause/mtval/mstatus). Issues a PC redirect to the fetch stage
//  through a valid/ready handshake. Also executes mret and owns M-mode trap CSRs.
// PARAMETERS
//  RESET_MTVEC  32'h0000_0000  mtvec value after reset
// PORTS
//  clk             in   1   single clock, rising edge
//  resetn          in   1   asynchronous, active-low reset
//  trap_req        in   1   exception request pulse (1 cycle)
//  trap_cause      in   32  exception code (bit31 = 0)
//  trap_pc         in   32  faulting PC
//  trap_tval       in   32  bad address / value
//  irq_ext         in   1   machine external interrupt level (mip.MEIP)
//  irq_pc          in   32  PC to resume at after an interrupt
//  mret            in   1   mret retired (1-cycle pulse)
//  csr_we          in   1   CSR write strobe
//  csr_addr        in   12  CSR address
//  csr_wdata       in   32  CSR write data
//  csr_rdata       out  32  CSR read data, combinational on csr_addr
//  redirect_valid  out  1   redirect_pc is valid
//  redirect_pc     out  32  new fetch PC
//  redirect_ready  in   1   fetch accepts redirect
//  busy            out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset is asynchronous, active-low. Forces state IDLE. All CSRs=0 except mtvec=RESET_MTVEC.
//   Also redirect_valid=0, redirect_pc=0, busy=0. Reset mid-redirect drops valid immediately.
//  CSR map: 0x300 mstatus (MIE[3], MPIE[7] rw; MPP[12:11] reads 2'b11), 0x304 mie
//   (bit11 only), 0x305 mtvec, 0x341 mepc (bits[1:0] forced 0), 0x342 mcause,
//   0x343 mtval, 0x344 mip (read-only, bit11=irq_ext). Unmapped: read 0, writes ignored.
//  FSM: IDLE -> REDIR -> IDLE. Priority in IDLE: trap_req > interrupt > mret.
//   Interrupt condition: mstatus.MIE & mie[11] & irq_ext.
//  Trap entry (exception or interrupt), at the accepting edge:
//   - mepc <= {pc[31:2],2'b00}
//   - mcause <= trap_cause, or 32'h8000_000B for an interrupt
//   - mtval <= trap_tval, or 0 for an interrupt
//   - MPIE <= MIE, MIE <= 0
//   - redirect_pc <= vector target; redirect_valid <= 1; state -> REDIR
//  mret in IDLE: MIE <= MPIE, MPIE <= 1; redirect_pc <= mepc; valid <= 1; -> REDIR.
//  Latency: redirect_valid rises 1 cycle after the request edge.
//  REDIR: redirect_valid and redirect_pc hold stable until redirect_ready=1.
//   On that edge, valid <= 0 and state -> IDLE. A new request can be accepted in
//   the following cycle. trap_req/mret arriving while busy are dropped; the
//   pipeline must stall on busy.
//  Same-cycle CSR write and trap/mret: trap/mret update wins for mstatus, mepc,
//   mcause, mtval. Writes to mie/mtvec complete normally.
//  All PC arithmetic is 32-bit modulo 2^32. Vector offset = cause[30:0]<<2.
// CONFIGURATION
//  VECTORED_MTVEC_EN defined:
//   - mtvec[1:0] writable
//   - mode 2'b01 + interrupt: target = {mtvec[31:2],2'b00} + (code<<2)
//   - exceptions, or mode 2'b00: target = base
//   - modes 2'b10/2'b11 behave as 2'b00
//  Not defined: mtvec[1:0] read 0 and ignore writes; target = base always.
// TESTING
//  T1 reset: resetn=0 mid-REDIR -> valid=0, busy=0, mstatus=0, mtvec=RESET_MTVEC.
//  T2 exception: mtvec=0x100, MIE=1, trap_req, cause=0, pc=0x2002, tval=0x2002
//     -> next cycle valid=1, pc=0x100; mepc=0x2000, mcause=0, MIE=0, MPIE=1.
//  T3 handshake: hold redirect_ready=0 for 3 cycles -> valid and pc stable.
//     ready=1 -> valid=0 next edge, busy=0.
//  T4 mret: after T2 completes, pulse mret -> redirect_pc=0x2000, MIE=1, MPIE=1.
//  T5 priority/drop: trap_req+irq_ext+mret in same IDLE cycle -> exception taken.
//     trap_req while busy -> ignored, mcause unchanged.
//  T6 vectored (EN): mtvec=0x101, mie=0x800, MIE=1, irq_ext=1, irq_pc=0x40
//     -> redirect_pc=0x12C, mcause=0x8000000B, mepc=0x40. Without EN -> 0x100.

Source files
------------

// File: rtl/trap_handler.sv
// Machine-mode trap consumer: saves mepc/mcause/mtval/mstatus, runs mret, owns M-mode trap CSRs, redirects fetch.
// Latency: redirect_valid rises one cycle after the accepting edge; csr_rdata is combinational on csr_addr.
// Backpressure: redirect held stable until redirect_ready; trap_req/mret seen while busy are dropped.
// Optional feature macro VECTORED_MTVEC_EN: enables mtvec mode bits and vectored interrupt targets.
module trap_handler #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        irq_ext,
  input  logic [31:0] irq_pc,
  input  logic        mret,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  typedef enum logic {IDLE, REDIR} state_t;

  localparam logic [31:0] IRQ_CAUSE = 32'h8000_000B;
  localparam logic [31:0] PC_MASK   = 32'hFFFF_FFFC;

  state_t      state;
  logic        st_mie;
  logic        st_mpie;
  logic        mie_meie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;

  logic        take_exc;
  logic        take_irq;
  logic        take_trap;
  logic        take_mret;
  logic [31:0] new_cause;
  logic [31:0] entry_pc;
  logic [31:0] trap_target;

  // Arbitrate requests in IDLE (exception > interrupt > mret) and compute the vector target.
  always_comb begin
    take_exc    = (state == IDLE) && trap_req;
    take_irq    = (state == IDLE) && !trap_req && st_mie && mie_meie && irq_ext;
    take_trap   = take_exc || take_irq;
    take_mret   = (state == IDLE) && !trap_req && !take_irq && mret;
    new_cause   = take_irq ? IRQ_CAUSE : trap_cause;
    entry_pc    = take_irq ? irq_pc : trap_pc;
    trap_target = mtvec & PC_MASK;
`ifdef VECTORED_MTVEC_EN
    if (take_irq && (mtvec[1:0] == 2'b01))
      trap_target = (mtvec & PC_MASK) + {new_cause[29:0], 2'b00};
`endif
  end

  // CSR read mux; MPP is hard-wired to machine mode.
  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      12'h300: csr_rdata = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      12'h304: csr_rdata = {20'b0, mie_meie, 11'b0};
`ifdef VECTORED_MTVEC_EN
      12'h305: csr_rdata = mtvec;
`else
      12'h305: csr_rdata = mtvec & PC_MASK;
`endif
      12'h341: csr_rdata = mepc;
      12'h342: csr_rdata = mcause;
      12'h343: csr_rdata = mtval;
      12'h344: csr_rdata = {20'b0, irq_ext, 11'b0};
      default: csr_rdata = 32'h0;
    endcase
  end

  // CSR state: software writes first, trap entry / mret override the trap-state CSRs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mie_meie <= 1'b0;
`ifdef VECTORED_MTVEC_EN
      mtvec    <= RESET_MTVEC;
`else
      mtvec    <= RESET_MTVEC & PC_MASK;
`endif
      mepc     <= 32'h0;
      mcause   <= 32'h0;
      mtval    <= 32'h0;
    end else begin
      if (csr_we) begin
        case (csr_addr)
          12'h300: begin
            st_mie  <= csr_wdata[3];
            st_mpie <= csr_wdata[7];
          end
          12'h304: mie_meie <= csr_wdata[11];
`ifdef VECTORED_MTVEC_EN
          12'h305: mtvec <= csr_wdata;
`else
          12'h305: mtvec <= csr_wdata & PC_MASK;
`endif
          12'h341: mepc   <= csr_wdata & PC_MASK;
          12'h342: mcause <= csr_wdata;
          12'h343: mtval  <= csr_wdata;
          default: ;
        endcase
      end
      if (take_trap) begin
        mepc    <= entry_pc & PC_MASK;
        mcause  <= new_cause;
        mtval   <= take_irq ? 32'h0 : trap_tval;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (take_mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
    end
  end

  // Redirect FSM: launch on accepted trap/mret, hold until fetch takes it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (take_trap) begin
            redirect_pc    <= trap_target;
            redirect_valid <= 1'b1;
            state          <= REDIR;
          end else if (take_mret) begin
            redirect_pc    <= mepc;
            redirect_valid <= 1'b1;
            state          <= REDIR;
          end
        end
        REDIR: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_trap_handler.sv
// Scoreboard bench for trap_handler: directed trap/mret/reset scenarios followed by random traffic.
// Expected redirects and CSR reads are queued by the driver and checked by an independent monitor.
module tb_trap_handler;
  localparam logic [31:0] TB_MTVEC = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_cause = 32'h0;
  logic [31:0] trap_pc = 32'h0;
  logic [31:0] trap_tval = 32'h0;
  logic        irq_ext = 1'b0;
  logic [31:0] irq_pc = 32'h0;
  logic        mret = 1'b0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = 12'h0;
  logic [31:0] csr_wdata = 32'h0;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  trap_handler #(.RESET_MTVEC(TB_MTVEC)) dut (
    .clk(clk), .resetn(resetn),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .irq_ext(irq_ext), .irq_pc(irq_pc), .mret(mret),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .busy(busy)
  );

  // Architectural reference state
  bit          m_mie, m_mpie, m_meie, m_busy;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;

  logic [31:0] exp_redir[$];
  logic [31:0] exp_csr[$];
  logic [11:0] chk_addr = 12'h0;
  bit          csr_chk = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0; m_meie = 0; m_busy = 0;
`ifdef VECTORED_MTVEC_EN
    m_mtvec = TB_MTVEC;
`else
    m_mtvec = TB_MTVEC & ~32'h3;
`endif
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
  endfunction

  function automatic logic [31:0] model_read(logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h304: return m_meie ? 32'h800 : 32'h0;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return irq_ext ? 32'h800 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of architectural behaviour, using the inputs presented to that edge.
  function automatic void model_step();
    bit          take = 0, irq = 0, do_mret = 0;
    bit          old_mie = m_mie, old_mpie = m_mpie;
    logic [31:0] tgt = 32'h0;
    logic [31:0] cause_v;
    if (!m_busy) begin
      if (trap_req) take = 1;
      else if (m_mie && m_meie && irq_ext) begin take = 1; irq = 1; end
      else if (mret) do_mret = 1;
    end
    cause_v = irq ? 32'h8000_000B : trap_cause;
    if (take) begin
      tgt = m_mtvec & ~32'h3;
`ifdef VECTORED_MTVEC_EN
      if (irq && (m_mtvec % 4 == 1)) tgt = tgt + (cause_v & 32'h7FFF_FFFF) * 4;
`endif
    end
    if (do_mret) tgt = m_mepc;
    if (m_busy && redirect_ready) m_busy = 0;
    if (csr_we) begin
      case (csr_addr)
        12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
        12'h304: m_meie = csr_wdata[11];
`ifdef VECTORED_MTVEC_EN
        12'h305: m_mtvec = csr_wdata;
`else
        12'h305: m_mtvec = csr_wdata & ~32'h3;
`endif
        12'h341: m_mepc = csr_wdata & ~32'h3;
        12'h342: m_mcause = csr_wdata;
        12'h343: m_mtval = csr_wdata;
        default: ;
      endcase
    end
    if (take) begin
      m_mepc   = (irq ? irq_pc : trap_pc) & ~32'h3;
      m_mcause = cause_v;
      m_mtval  = irq ? 32'h0 : trap_tval;
      m_mpie   = old_mie;
      m_mie    = 0;
      m_busy   = 1;
      exp_redir.push_back(tgt);
    end else if (do_mret) begin
      m_mie  = old_mpie;
      m_mpie = 1;
      m_busy = 1;
      exp_redir.push_back(tgt);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (resetn) model_step();
    #1;
    trap_req = 0; mret = 0; csr_we = 0; csr_chk = 0;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_addr = a;
    chk_addr = a;
    exp_csr.push_back(model_read(a));
    csr_chk = 1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1;
    csr_wdata = d;
    rd(a);
  endtask

  // Monitor: compares DUT outputs with the queued expectations, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_busy});
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      if (m_busy && exp_redir.size() > 0) begin
        chk("redirect_pc", redirect_pc, exp_redir[0]);
        if (redirect_ready) void'(exp_redir.pop_front());
      end
      if (csr_chk) begin
        if (exp_csr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL csr_queue: got empty expected entry for addr %h", chk_addr);
        end else begin
          chk($sformatf("csr_rdata[%h]", chk_addr), csr_rdata, exp_csr.pop_front());
        end
      end
    end
  end

  logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};

  initial begin
    model_reset();
    @(posedge clk); #2;
    // Reset values
    rd(12'h305); tick();
    rd(12'h300); tick();
    resetn = 1;
    // Exception entry
    wr(12'h305, 32'h100); tick();
    wr(12'h300, 32'h8); tick();
    trap_req = 1; trap_cause = 0; trap_pc = 32'h2002; trap_tval = 32'h2002;
    redirect_ready = 0; rd(12'h341); tick();
    rd(12'h341); tick();
    rd(12'h342); tick();
    // Held redirect, plus a trap_req while busy that must be dropped
    trap_req = 1; trap_cause = 5; rd(12'h300); tick();
    rd(12'h342); tick();
    redirect_ready = 1; rd(12'h343); tick();
    redirect_ready = 0; tick();
    // mret back to mepc
    mret = 1; rd(12'h300); tick();
    rd(12'h300); redirect_ready = 1; tick();
    redirect_ready = 0;
    // Priority: exception, interrupt and mret together
    wr(12'h304, 32'h800); tick();
    trap_req = 1; trap_cause = 2; trap_pc = 32'h3000; trap_tval = 32'h77;
    irq_ext = 1; mret = 1; rd(12'h344); tick();
    rd(12'h342); redirect_ready = 1; tick();
    irq_ext = 0; redirect_ready = 0; rd(12'h300); tick();
    // Return with MIE=1, then take the external interrupt
    wr(12'h305, 32'h101); tick();
    mret = 1; tick();
    redirect_ready = 1; tick();
    redirect_ready = 0; irq_ext = 1; irq_pc = 32'h40; rd(12'h300); tick();
    rd(12'h342); tick();
    rd(12'h341); tick();
    // Reset while a redirect is pending
    resetn = 0; model_reset(); exp_redir.delete(); irq_ext = 0; rd(12'h300); tick();
    rd(12'h305); tick();
    resetn = 1; rd(12'h304); tick();
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      trap_req       = ($urandom_range(0, 3) == 0);
      trap_cause     = $urandom & 32'h7FFF_FFFF;
      trap_pc        = $urandom;
      trap_tval      = $urandom;
      irq_ext        = ($urandom_range(0, 2) == 0);
      irq_pc         = $urandom;
      mret           = ($urandom_range(0, 4) == 0);
      redirect_ready = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 3) == 0)
        wr(addrs[$urandom_range(0, 7)], $urandom);
      else
        rd(addrs[$urandom_range(0, 7)]);
      tick();
    end
    // Drain any pending redirect
    trap_req = 0; mret = 0; irq_ext = 0; redirect_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
